// File: rtl/fpu_round_pack.sv
// fpu_round_pack: normalizes, rounds to nearest even and packs an unpacked single-precision result.
module fpu_round_pack (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [8:0]  in_exp,
  input  logic [26:0] in_mantissa,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_overflow,
  output logic        out_underflow,
  output logic        out_inexact
);
  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;
  state_t state, state_nxt;
  logic        sign_r;
  logic [9:0]  exp_r;
  logic [26:0] mant_r;
  logic        norm_done, inc, rzero, rovf, rhid, rinx;
  logic [24:0] rsum;
  logic [9:0]  rexp;
  logic [31:0] res;
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = in_valid ? NORM : IDLE;
      NORM:    state_nxt = norm_done ? ROUND : NORM;
      ROUND:   state_nxt = DONE;
      default: state_nxt = out_ready ? IDLE : DONE;
    endcase
  end
  always_comb begin
    in_ready  = state == IDLE;
    out_valid = state == DONE;
  end
  assign norm_done = mant_r[26] | ~|mant_r | mant_r[25] | (exp_r == 10'd1);
  // Hidden bit joins the 24-bit add so a carry out of the fraction lands in rsum[24].
  assign inc   = mant_r[1] & (mant_r[0] | mant_r[2]);
  assign rsum  = {1'b0, mant_r[25:2]} + 25'(inc);
  assign rexp  = exp_r + 10'(rsum[24]);
  assign rinx  = mant_r[1] | mant_r[0];
  assign rzero = ~|mant_r;
  assign rovf  = !rzero && rexp >= 10'd255;
  assign rhid  = rsum[24] | rsum[23];
  assign res   = rzero ? {sign_r, 31'h0} :
                 rovf  ? {sign_r, 8'hFF, 23'h0} :
                         {sign_r, rhid ? rexp[7:0] : 8'h00, rsum[22:0]};
  always_ff @(posedge clk)
    if (rst) begin
      sign_r        <= 1'b0;
      exp_r         <= '0;
      mant_r        <= '0;
      out_result    <= '0;
      out_overflow  <= 1'b0;
      out_underflow <= 1'b0;
      out_inexact   <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      sign_r <= in_sign;
      exp_r  <= {1'b0, in_exp == 9'd0 ? 9'd1 : in_exp};
      mant_r <= in_mantissa;
    end else if (state == NORM && mant_r[26]) begin
      mant_r <= {1'b0, mant_r[26:3], mant_r[2], |mant_r[1:0]};
      exp_r  <= exp_r + 10'd1;
    end else if (state == NORM && !norm_done) begin
      mant_r <= {mant_r[25:0], 1'b0};
      exp_r  <= exp_r - 10'd1;
    end else if (state == ROUND) begin
      out_result    <= res;
      out_overflow  <= rovf;
      out_underflow <= !rzero && !rovf && !rhid && rinx;
      out_inexact   <= !rzero && (rovf || rinx);
    end
endmodule
